fact_accel: RTL and testbench
=============================

# fact_accel

Memory-mapped iterative factorial accelerator: the bus-responder end of the factorial test flow. The CPU stores `n`, writes GO, polls STATUS, and reads RESULT, replacing the software loop whose output the system bench checks on `gpO2`. It sits behind the SoC address decoder beside the GPIO block and shares the processor clock. Each cycle it performs one multiply by a down-counter and flags results that would overflow 32 bits.

## Interface
- No parameters; the register map and widths below are fixed.
- `clk`  in  1  processor clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  write strobe, already qualified by the SoC decoder for this block's address range.
- `a`  in  2  word select: 0 N, 1 GO, 2 STATUS, 3 RESULT.
- `wd`  in  32  write data.
- `rd`  out  32  read data, combinational from `a` and the registers.

## Operation
- **Registers**
  - N: read/write, bits [3:0]; upper bits read 0.
  - GO: write only. Writing bit0=1 requests a start. A read returns {31'b0, busy}.
  - STATUS: read only, {30'b0, err, done}.
  - RESULT: read only, 32 bits.
  - Writes to STATUS or RESULT are ignored.
- **States:** IDLE and RUN. Internal state is `cnt[3:0]` and `prod[31:0]`.
- **IDLE, GO write with wd[0]=1, N ≤ 12:**
  - go to RUN;
  - `cnt` ← N, `prod` ← 1;
  - done ← 0, err ← 0.
- **IDLE, GO write with wd[0]=1, N ≥ 13:**
  - stay in IDLE;
  - err ← 1, done ← 1, RESULT ← 0.
- **RUN, `cnt` > 1:** `prod` ← low 32 bits of `prod`×`cnt`; `cnt` ← `cnt`−1.
- **RUN, `cnt` ≤ 1:**
  - RESULT ← `prod`, done ← 1;
  - go to IDLE.
- **Arithmetic:** a 32×4 unsigned multiply. No overflow is possible for N ≤ 12 (12! = 479001600).
- **Writes while busy:**
  - GO writes are ignored.
  - N writes update the N register but do not affect the running computation, which uses the latched `cnt`.
- **Stale state:** done and err hold until the next accepted start or reset. RESULT holds its last value until the next completion, error, or reset.
- **Reset:** takes priority over everything, including mid-RUN. It returns the block to IDLE and clears N, `cnt`, `prod`, RESULT, done, err and busy (`prod` clears to 0, not 1).

## Timing
- **Reset values:** `rd` reads 0 for every `a`; busy = 0, done = 0, err = 0, RESULT = 0.
- **Start:** the GO write is accepted on edge E0, and busy = 1 after E0.
- **Completion:** done rises and busy falls after edge E(max(N,1)).
  - N = 0 or N = 1: after E1.
  - N = 5: after E5.
  - N = 12: after E12.
- **Error case (N ≥ 13):** done = 1 and err = 1 are visible right after E0; busy never asserts.
- **Read behaviour:** `rd` has no read latency and reflects register state in the same cycle. A read of STATUS in the cycle done rises returns the new value, since the register has already updated at that edge.
- **Write plus start in one cycle:** a start that uses a new N needs the N write on one edge and the GO write on a later edge. A single bus port allows only one write per cycle.

## Test plan
- **n = 5:** reset, write N=5, write GO=1 → busy=1 for edges E1–E4; after E5 STATUS=0x1 and RESULT=120.
- **n = 0 and n = 1:** each → STATUS=0x1 and RESULT=1 after E1; busy high for exactly one cycle.
- **n = 12:** → RESULT=479001600 (0x1C8CFC00) after E12, err=0. Then sweep n = 0..12 back-to-back against a reference factorial.
- **n = 13:** write N=13, GO=1 → after E0 STATUS=0x3, RESULT=0, GO reads 0.
- **Writes while busy:** during an n=6 run, at E2 write GO=1 and N=3 → run still completes with RESULT=720 after E6; N reads 3 afterwards.
- **Reset mid-run:** assert `rst` for one edge at E3 of an n=8 run → all registers read 0; busy=0; a fresh n=4 run then returns 24 after E4.

Source files
------------

// File: rtl/fact_accel_if.sv
// Register-bus connection between the SoC decoder and the factorial accelerator.
// The decoder drives the write side; the accelerator returns read data.
interface fact_accel_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output we, output a, output wd, input  rd);
    modport slave  (input  we, input  a, input  wd, output rd);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial engine: one 32x4 multiply per cycle while
// counting n down, with an error flag for n values whose result exceeds 32 bits.
module fact_accel (
    input  logic         clk,
    input  logic         rst,
    fact_accel_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_W    = 4;

    localparam logic [1:0]     A_N      = 2'd0;
    localparam logic [1:0]     A_GO     = 2'd1;
    localparam logic [1:0]     A_STATUS = 2'd2;
    localparam logic [1:0]     A_RESULT = 2'd3;
    localparam logic [N_W-1:0] N_MAX    = N_W'(12);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_W-1:0]      r_n;
    logic [N_W-1:0]      r_cnt;
    logic [DATA_W-1:0]   r_prod;
    logic [DATA_W-1:0]   r_result;
    logic                r_done;
    logic                r_err;

    logic                w_wr_n;
    logic                w_wr_go;
    logic                w_start;
    logic                w_reject;
    logic                w_step;
    logic                w_finish;
    logic                w_busy;
    logic [DATA_W-1:0]   w_mul;
    logic                w_unused;

    assign w_wr_n   = bus.we && (bus.a == A_N);
    assign w_wr_go  = bus.we && (bus.a == A_GO) && bus.wd[0];
    assign w_busy   = (r_state == S_RUN);
    assign w_mul    = r_prod * DATA_W'(r_cnt);
    assign w_unused = ^bus.wd[DATA_W-1:N_W];

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and datapath strobes; GO is only honoured while idle
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_go) begin
                    if (r_n <= N_MAX) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt > N_W'(1)) begin
                    w_step = 1'b1;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registers and datapath; N stays writable while a run uses the latched cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n      <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_n) r_n <= bus.wd[N_W-1:0];
            if (w_start) begin
                r_cnt  <= r_n;
                r_prod <= DATA_W'(1);
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_reject) begin
                r_err    <= 1'b1;
                r_done   <= 1'b1;
                r_result <= '0;
            end else if (w_step) begin
                r_prod <= w_mul;
                r_cnt  <= r_cnt - N_W'(1);
            end else if (w_finish) begin
                r_result <= r_prod;
                r_done   <= 1'b1;
            end
        end
    end

    // Zero-latency read mux
    always_comb begin
        bus.rd = '0;
        case (bus.a)
            A_N:      bus.rd = {{(DATA_W-N_W){1'b0}}, r_n};
            A_GO:     bus.rd = {{(DATA_W-1){1'b0}}, w_busy};
            A_STATUS: bus.rd = {{(DATA_W-2){1'b0}}, r_err, r_done};
            A_RESULT: bus.rd = r_result;
            default:  bus.rd = '0;
        endcase
    end
endmodule

// File: tb/tb_fact_accel.sv
// Directed self-checking bench for fact_accel: timing of busy/done, results,
// error path, writes during a run and reset mid-run.
module tb_fact_accel;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fact_accel_if bus ();

    fact_accel u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one write that is taken on the next rising edge
    task automatic bus_wr(input logic [1:0] addr, input logic [31:0] data);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        step();
        bus.we = 1'b0;
        bus.wd = '0;
    endtask

    task automatic bus_rd(input logic [1:0] addr, output logic [31:0] val);
        bus.a = addr;
        #1;
        val = bus.rd;
    endtask

    task automatic do_run(input logic [3:0] n, input logic [31:0] exp_res,
                          input int exp_edges, input string tag);
        logic [31:0] v;
        int          edges;
        bus_wr(2'd0, 32'(n));
        bus_wr(2'd1, 32'd1);
        bus_rd(2'd1, v);
        chk({tag, " busy after E0"}, v, 32'd1);
        edges = 0;
        v     = '0;
        while (edges < 40 && v[0] !== 1'b1) begin
            step();
            edges++;
            bus_rd(2'd2, v);
        end
        chk({tag, " edges to done"}, 32'(edges), 32'(exp_edges));
        chk({tag, " status"}, v, 32'h1);
        bus_rd(2'd3, v);
        chk({tag, " result"}, v, exp_res);
        bus_rd(2'd1, v);
        chk({tag, " busy after done"}, v, 32'd0);
    endtask

    logic [31:0] fact_tbl [0:12] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120,
                                     32'd720, 32'd5040, 32'd40320, 32'd362880,
                                     32'd3628800, 32'd39916800, 32'd479001600};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        n_checks = 0;
        n_fail   = 0;
        bus.we = 1'b0;
        bus.a  = '0;
        bus.wd = '0;
        rst    = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset values
        for (int i = 0; i < 4; i++) begin
            bus_rd(2'(i), v);
            chk($sformatf("reset rd a=%0d", i), v, 32'd0);
        end

        // n = 5 with cycle-by-cycle busy
        bus_wr(2'd0, 32'd5);
        bus_rd(2'd0, v);
        chk("N readback 5", v, 32'd5);
        bus_wr(2'd1, 32'd1);
        bus_rd(2'd1, v);
        chk("n5 busy E0", v, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            bus_rd(2'd1, v);
            chk($sformatf("n5 busy E%0d", k), v, 32'd1);
            bus_rd(2'd2, v);
            chk($sformatf("n5 status E%0d", k), v, 32'd0);
        end
        step();
        bus_rd(2'd2, v);
        chk("n5 status E5", v, 32'h1);
        bus_rd(2'd3, v);
        chk("n5 result", v, 32'd120);
        bus_rd(2'd1, v);
        chk("n5 busy E5", v, 32'd0);

        // Upper write bits of N ignored
        bus_wr(2'd0, 32'hFFFF_FFF3);
        bus_rd(2'd0, v);
        chk("N upper bits", v, 32'd3);

        do_run(4'd0, 32'd1, 1, "n0");
        do_run(4'd1, 32'd1, 1, "n1");
        do_run(4'd12, 32'h1C8C_FC00, 12, "n12");

        // Sweep 0..12
        for (int n = 0; n <= 12; n++)
            do_run(4'(n), fact_tbl[n], (n < 1) ? 1 : n, $sformatf("sweep%0d", n));

        // Writes to STATUS/RESULT ignored
        bus_wr(2'd3, 32'hDEAD_BEEF);
        bus_wr(2'd2, 32'h0000_0002);
        bus_rd(2'd3, v);
        chk("result write ignored", v, 32'd479001600);
        bus_rd(2'd2, v);
        chk("status write ignored", v, 32'h1);

        // n = 13 error path
        bus_wr(2'd0, 32'd13);
        bus_wr(2'd1, 32'd1);
        bus_rd(2'd2, v);
        chk("n13 status", v, 32'h3);
        bus_rd(2'd3, v);
        chk("n13 result", v, 32'd0);
        bus_rd(2'd1, v);
        chk("n13 busy", v, 32'd0);
        step();
        bus_rd(2'd1, v);
        chk("n13 busy later", v, 32'd0);
        bus_rd(2'd2, v);
        chk("n13 status holds", v, 32'h3);
        do_run(4'd3, 32'd6, 3, "after err n3");

        // GO with wd[0]=0 does not start
        bus_wr(2'd1, 32'h2);
        bus_rd(2'd1, v);
        chk("GO bit0=0 no start", v, 32'd0);

        // Writes while busy during n = 6
        bus_wr(2'd0, 32'd6);
        bus_wr(2'd1, 32'd1);
        step();
        bus_wr(2'd1, 32'd1);
        bus_wr(2'd0, 32'd3);
        step();
        step();
        bus_rd(2'd1, v);
        chk("n6 busy E5", v, 32'd1);
        step();
        bus_rd(2'd2, v);
        chk("n6 status E6", v, 32'h1);
        bus_rd(2'd3, v);
        chk("n6 result", v, 32'd720);
        bus_rd(2'd0, v);
        chk("n6 N after", v, 32'd3);
        step();
        bus_rd(2'd1, v);
        chk("n6 no restart", v, 32'd0);

        // Reset mid-run of n = 8
        bus_wr(2'd0, 32'd8);
        bus_wr(2'd1, 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_rd(2'(i), v);
            chk($sformatf("midrun reset a=%0d", i), v, 32'd0);
        end
        step();
        bus_rd(2'd1, v);
        chk("midrun reset stays idle", v, 32'd0);
        do_run(4'd4, 32'd24, 4, "post reset n4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
